// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single 16-bit memory bus between the nlp16af
// core (fixed priority, no wait input) and a host master. Unlocked host
// accesses use idle core cycles; a locked session holds the core in reset,
// gives the host the bus exclusively, then releases the core after a fixed
// reset hold.
//
// Host handshake: the host raises i_host_req with i_host_wr/addr/wdata and
// holds them stable until it sees o_host_ack. o_host_gnt marks the single
// cycle in which the host access reaches memory; o_host_ack is a one-cycle
// pulse on the following cycle, with read data in o_host_rdata. No grant is
// given in an ack cycle, so a request still held after ack is a new access.
module mem_bus_arbiter #(
  parameter int RST_HOLD     = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_core_wr,
  input  logic        i_core_rd,
  input  logic [15:0] i_core_addr,
  input  logic [15:0] i_core_wdata,
  output logic [15:0] o_core_rdata,
  output logic        o_core_rst_n,
  input  logic        i_host_req,
  input  logic        i_host_lock,
  input  logic        i_host_wr,
  input  logic [15:0] i_host_addr,
  input  logic [15:0] i_host_wdata,
  output logic        o_host_gnt,
  output logic        o_host_ack,
  output logic [15:0] o_host_rdata,
  output logic        o_host_starve,
  output logic        o_mem_wr,
  output logic        o_mem_rd,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  input  logic [15:0] i_mem_rdata,
  output logic [1:0]  o_state_dbg
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(RST_HOLD - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALT    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            core_rst_n_q, core_rst_n_d;
  logic            ack_q, ack_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            starve_q, starve_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic            in_run, in_halt, gnt;

  assign in_run  = (state_q == ST_RUN);
  assign in_halt = (state_q == ST_HALT);

  // Host may use the bus in RUN only when the core is idle and no lock is
  // pending; in HALT it owns the bus. Never in an ack cycle.
  assign gnt = i_host_req & ~ack_q &
               ((in_run & ~i_core_rd & ~i_core_wr & ~i_host_lock) | in_halt);

  assign o_host_gnt    = gnt;
  assign o_host_ack    = ack_q;
  assign o_host_rdata  = rdata_q;
  assign o_host_starve = starve_q;
  assign o_core_rst_n  = core_rst_n_q;
  assign o_core_rdata  = i_mem_rdata;
  assign o_state_dbg   = state_q;

  // Memory mux: granted host, else core in RUN, else quiet bus.
  always_comb begin
    o_mem_wr    = 1'b0;
    o_mem_rd    = 1'b0;
    o_mem_addr  = 16'h0000;
    o_mem_wdata = 16'h0000;
    if (gnt) begin
      o_mem_wr    = i_host_wr;
      o_mem_rd    = ~i_host_wr;
      o_mem_addr  = i_host_addr;
      o_mem_wdata = i_host_wdata;
    end else if (in_run) begin
      o_mem_wr    = i_core_wr;
      o_mem_rd    = i_core_rd;
      o_mem_addr  = i_core_addr;
      o_mem_wdata = i_core_wdata;
    end
  end

  // Next-state logic for the ownership FSM and the release hold counter.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_RUN: begin
        if (i_host_req & i_host_lock & ~ack_q) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (~i_host_lock & ~gnt & ~ack_q) begin
          state_d = ST_RELEASE;
          hold_d  = '0;
        end
      end
      ST_RELEASE: begin
        if (i_host_req & i_host_lock) state_d = ST_HALT;
        else if (hold_q == HOLD_LAST) state_d = ST_RUN;
        else hold_d = hold_q + HW'(1);
      end
      default: state_d = ST_RELEASE;
    endcase
    // Core reset follows the state being entered, so it changes on the
    // same edge as the state.
    core_rst_n_d = (state_d == ST_RUN);
  end

  // Transfer completion and starvation tracking.
  always_comb begin
    ack_d   = gnt;
    rdata_d = (gnt & ~i_host_wr) ? i_mem_rdata : rdata_q;
    scnt_d  = scnt_q;
    if (~i_host_req | ack_q) scnt_d = '0;
    else if (in_run & ~gnt & (scnt_q < STARVE_MAX)) scnt_d = scnt_q + SW'(1);
    starve_d = (scnt_d >= STARVE_MAX);
  end

  // State registers; reset discards any pending ack.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_RELEASE;
      hold_q       <= '0;
      core_rst_n_q <= 1'b0;
      ack_q        <= 1'b0;
      rdata_q      <= 16'h0000;
      starve_q     <= 1'b0;
      scnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      core_rst_n_q <= core_rst_n_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      starve_q     <= starve_d;
      scnt_q       <= scnt_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter.
module tb_mem_bus_arbiter;

  localparam logic [1:0] S_RUN = 2'd0, S_HALT = 2'd1, S_REL = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_wr, core_rd;
  logic [15:0] core_addr, core_wdata, core_rdata;
  logic        core_rst_n;
  logic        host_req, host_lock, host_wr;
  logic [15:0] host_addr, host_wdata;
  logic        host_gnt, host_ack, host_starve;
  logic [15:0] host_rdata;
  logic        mem_wr, mem_rd;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  // Clock and DUT.
  always #5 clk = ~clk;

  mem_bus_arbiter #(.RST_HOLD(4), .STARVE_LIMIT(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_core_wr    (core_wr),
    .i_core_rd    (core_rd),
    .i_core_addr  (core_addr),
    .i_core_wdata (core_wdata),
    .o_core_rdata (core_rdata),
    .o_core_rst_n (core_rst_n),
    .i_host_req   (host_req),
    .i_host_lock  (host_lock),
    .i_host_wr    (host_wr),
    .i_host_addr  (host_addr),
    .i_host_wdata (host_wdata),
    .o_host_gnt   (host_gnt),
    .o_host_ack   (host_ack),
    .o_host_rdata (host_rdata),
    .o_host_starve(host_starve),
    .o_mem_wr     (mem_wr),
    .o_mem_rd     (mem_rd),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata),
    .o_state_dbg  (state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    core_wr = 0; core_rd = 0; core_addr = 0; core_wdata = 0;
    host_req = 0; host_lock = 0; host_wr = 0; host_addr = 0; host_wdata = 0;
    mem_rdata = 0;
    #1 rst_n = 1'b0;
    core_rd = 1; core_addr = 16'h0100;
    #1;
    // Reset values.
    chk("rst_core_rst_n", 32'(core_rst_n), 0);
    chk("rst_ack", 32'(host_ack), 0);
    chk("rst_rdata", 32'(host_rdata), 0);
    chk("rst_starve", 32'(host_starve), 0);
    chk("rst_state", 32'(state_dbg), 32'(S_REL));
    chk("rst_mem_rd", 32'(mem_rd), 0);
    step(); step();

    // 1: release after reset, core held for 4 cycles, no strobes.
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rel_core_rst_n", 32'(core_rst_n), 0);
      chk("rel_mem_rd", 32'(mem_rd), 0);
      chk("rel_state", 32'(state_dbg), 32'(S_REL));
      step(); #1;
    end
    chk("run_core_rst_n", 32'(core_rst_n), 1);
    chk("run_mem_rd", 32'(mem_rd), 1);
    chk("run_mem_addr", 32'(mem_addr), 32'h0100);

    // 2: host write starved by busy core, then served on an idle cycle.
    host_req = 1; host_wr = 1; host_addr = 16'h2000; host_wdata = 16'hBEEF;
    #1;
    for (int i = 0; i < 16; i++) begin
      chk("stv_gnt", 32'(host_gnt), 0);
      chk("stv_starve_low", 32'(host_starve), 0);
      step(); #1;
    end
    chk("stv_starve_high", 32'(host_starve), 1);
    chk("stv_gnt_busy", 32'(host_gnt), 0);
    core_rd = 0;
    #1;
    chk("stv_gnt_idle", 32'(host_gnt), 1);
    chk("stv_mem_wr", 32'(mem_wr), 1);
    chk("stv_mem_rd", 32'(mem_rd), 0);
    chk("stv_mem_addr", 32'(mem_addr), 32'h2000);
    chk("stv_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    step();
    core_rd = 1; host_req = 0;
    #1;
    chk("stv_ack", 32'(host_ack), 1);
    chk("stv_ack_gnt", 32'(host_gnt), 0);
    chk("stv_starve_in_ack", 32'(host_starve), 1);
    chk("stv_core_pass", 32'(mem_rd), 1);
    step(); #1;
    chk("stv_ack_off", 32'(host_ack), 0);
    chk("stv_starve_clr", 32'(host_starve), 0);
    chk("stv_rdata_hold", 32'(host_rdata), 0);

    // 3: back-to-back host reads on an idle core.
    core_rd = 0;
    host_req = 1; host_wr = 0; host_addr = 16'h0040; mem_rdata = 16'h1234;
    #1;
    chk("rd_gnt", 32'(host_gnt), 1);
    chk("rd_mem_rd", 32'(mem_rd), 1);
    chk("rd_mem_wr", 32'(mem_wr), 0);
    chk("rd_mem_addr", 32'(mem_addr), 32'h0040);
    step();
    mem_rdata = 16'h5678;
    #1;
    chk("rd_ack", 32'(host_ack), 1);
    chk("rd_rdata", 32'(host_rdata), 32'h1234);
    chk("rd_ack_nogrant", 32'(host_gnt), 0);
    chk("rd_core_rdata", 32'(core_rdata), 32'h5678);
    step(); #1;
    chk("rd_regrant", 32'(host_gnt), 1);
    chk("rd_ack_clear", 32'(host_ack), 0);
    chk("rd_rdata_keep", 32'(host_rdata), 32'h1234);
    step();
    host_req = 0;
    #1;
    chk("rd2_ack", 32'(host_ack), 1);
    chk("rd2_rdata", 32'(host_rdata), 32'h5678);
    step(); #1;
    chk("rd2_ack_off", 32'(host_ack), 0);

    // 4: locked session with core strobes active.
    host_req = 1; host_lock = 1; host_wr = 1; host_addr = 16'h0000; host_wdata = 16'h00A0;
    core_wr = 1; core_addr = 16'h3333; core_wdata = 16'h7777;
    #1;
    chk("lk_run_gnt", 32'(host_gnt), 0);
    chk("lk_run_core_wr", 32'(mem_wr), 1);
    chk("lk_run_core_addr", 32'(mem_addr), 32'h3333);
    chk("lk_run_core_wdata", 32'(mem_wdata), 32'h7777);
    chk("lk_run_state", 32'(state_dbg), 32'(S_RUN));
    step(); #1;
    chk("lk_halt_state", 32'(state_dbg), 32'(S_HALT));
    chk("lk_halt_core_rst_n", 32'(core_rst_n), 0);
    chk("lk_w0_gnt", 32'(host_gnt), 1);
    chk("lk_w0_mem_wr", 32'(mem_wr), 1);
    chk("lk_w0_addr", 32'(mem_addr), 32'h0000);
    chk("lk_w0_wdata", 32'(mem_wdata), 32'h00A0);
    step();
    host_addr = 16'h0001; host_wdata = 16'h00A1;
    #1;
    chk("lk_w0_ack", 32'(host_ack), 1);
    chk("lk_w0_ack_gnt", 32'(host_gnt), 0);
    chk("lk_quiet_wr", 32'(mem_wr), 0);
    chk("lk_quiet_addr", 32'(mem_addr), 0);
    step(); #1;
    chk("lk_w1_gnt", 32'(host_gnt), 1);
    chk("lk_w1_addr", 32'(mem_addr), 32'h0001);
    chk("lk_w1_wdata", 32'(mem_wdata), 32'h00A1);
    chk("lk_w1_ack_off", 32'(host_ack), 0);
    step();
    host_addr = 16'h0002; host_wdata = 16'h00A2;
    #1;
    chk("lk_w1_ack", 32'(host_ack), 1);
    chk("lk_w1_ack_gnt", 32'(host_gnt), 0);
    step(); #1;
    chk("lk_w2_gnt", 32'(host_gnt), 1);
    chk("lk_w2_addr", 32'(mem_addr), 32'h0002);
    chk("lk_w2_wdata", 32'(mem_wdata), 32'h00A2);
    step();
    host_req = 0; host_lock = 0;
    #1;
    chk("lk_w2_ack", 32'(host_ack), 1);
    chk("lk_w2_state", 32'(state_dbg), 32'(S_HALT));
    step(); #1;
    chk("lk_unlock_state", 32'(state_dbg), 32'(S_HALT));
    chk("lk_unlock_ack", 32'(host_ack), 0);
    chk("lk_unlock_gnt", 32'(host_gnt), 0);
    step(); #1;
    for (int i = 0; i < 4; i++) begin
      chk("lk_rel_state", 32'(state_dbg), 32'(S_REL));
      chk("lk_rel_core_rst_n", 32'(core_rst_n), 0);
      chk("lk_rel_mem_wr", 32'(mem_wr), 0);
      step(); #1;
    end
    chk("lk_run_again", 32'(state_dbg), 32'(S_RUN));
    chk("lk_run_core_rst_n1", 32'(core_rst_n), 1);
    chk("lk_run_core_wr1", 32'(mem_wr), 1);
    core_wr = 0;

    // 5: lock raised in the ack cycle of an unlocked write.
    host_req = 1; host_wr = 1; host_addr = 16'h0010; host_wdata = 16'h5555;
    #1;
    chk("la_gnt", 32'(host_gnt), 1);
    chk("la_mem_wr", 32'(mem_wr), 1);
    chk("la_mem_addr", 32'(mem_addr), 32'h0010);
    step();
    host_lock = 1;
    #1;
    chk("la_ack", 32'(host_ack), 1);
    chk("la_ack_gnt", 32'(host_gnt), 0);
    chk("la_ack_state", 32'(state_dbg), 32'(S_RUN));
    step(); #1;
    chk("la_wait_state", 32'(state_dbg), 32'(S_RUN));
    chk("la_wait_ack", 32'(host_ack), 0);
    chk("la_wait_gnt", 32'(host_gnt), 0);
    chk("la_wait_core_rst_n", 32'(core_rst_n), 1);
    step(); #1;
    chk("la_halt_state", 32'(state_dbg), 32'(S_HALT));
    chk("la_halt_core_rst_n", 32'(core_rst_n), 0);
    chk("la_halt_gnt", 32'(host_gnt), 1);
    chk("la_halt_mem_wr", 32'(mem_wr), 1);

    // 6: asynchronous reset during a HALT transfer cycle.
    rst_n = 1'b0;
    #1;
    chk("ar_ack", 32'(host_ack), 0);
    chk("ar_gnt", 32'(host_gnt), 0);
    chk("ar_state", 32'(state_dbg), 32'(S_REL));
    chk("ar_core_rst_n", 32'(core_rst_n), 0);
    chk("ar_mem_wr", 32'(mem_wr), 0);
    chk("ar_mem_addr", 32'(mem_addr), 0);
    chk("ar_rdata", 32'(host_rdata), 0);
    chk("ar_starve", 32'(host_starve), 0);
    step(); #1;
    chk("ar_hold_ack", 32'(host_ack), 0);
    rst_n = 1'b1; host_req = 0; host_lock = 0;
    step(); #1;
    chk("ar_post_ack", 32'(host_ack), 0);
    chk("ar_post_state", 32'(state_dbg), 32'(S_REL));
    chk("ar_post_core_rst_n", 32'(core_rst_n), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
